// File: rtl/celltrng_sample_ctrl_pkg.sv
// Shared types and defaults for the cellTRNG sampling controller.
package celltrng_sample_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StChain,
        StWarmup,
        StRun,
        StFault
    } trng_ctrl_state_t;

    localparam int unsigned DefNumCells     = 3;
    localparam int unsigned DefSampleDiv    = 4;
    localparam int unsigned DefWarmupSamp   = 64;
    localparam int unsigned DefRepLimit     = 32;
    localparam int unsigned DefChainTimeout = 1024;

    // Counter width able to hold max_val itself, so terminal counts compare with ==.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/celltrng_sample_ctrl_vn_debias.sv
// Von Neumann de-biaser: pairs consecutive samples, emits the first bit of each unequal pair.
module celltrng_sample_ctrl_vn_debias (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic sample_i,
    input  logic data_i,
    output logic bit_valid_o,
    output logic bit_o
);

    logic phase_q, phase_d;
    logic first_q, first_d;

    always_comb begin
        phase_d     = phase_q;
        first_d     = first_q;
        bit_valid_o = 1'b0;
        bit_o       = first_q;
        if (clear_i) begin
            phase_d = 1'b0;
            first_d = 1'b0;
        end else if (sample_i) begin
            if (!phase_q) begin
                first_d = data_i;
                phase_d = 1'b1;
            end else begin
                phase_d     = 1'b0;
                bit_valid_o = (first_q != data_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/celltrng_sample_ctrl.sv
// cellTRNG controller: enable-chain sequencing, raw sampling, health test, de-biasing and
// byte delivery over a valid/ready interface.
module celltrng_sample_ctrl
    import celltrng_sample_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CELLS      = DefNumCells,
    parameter int unsigned SAMPLE_DIV     = DefSampleDiv,
    parameter int unsigned WARMUP_SAMPLES = DefWarmupSamp,
    parameter int unsigned REP_LIMIT      = DefRepLimit,
    parameter int unsigned CHAIN_TIMEOUT  = DefChainTimeout
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    output logic                 cell_enable_o,
    input  logic                 cell_chain_i,
    output logic [NUM_CELLS-1:0] cell_select_o,
    input  logic [NUM_CELLS-1:0] cell_data_i,
    output logic [7:0]           rnd_data_o,
    output logic                 rnd_valid_o,
    input  logic                 rnd_ready_i,
    output logic                 busy_o,
    output logic                 fault_o
);

    localparam int unsigned TmoW  = cnt_width(CHAIN_TIMEOUT);
    localparam int unsigned DivW  = cnt_width(SAMPLE_DIV);
    localparam int unsigned WarmW = cnt_width(WARMUP_SAMPLES);
    localparam int unsigned RepW  = cnt_width(REP_LIMIT);

    trng_ctrl_state_t     state_q, state_d;
    logic [NUM_CELLS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [WarmW-1:0]     warm_q, warm_d;
    logic [RepW-1:0]      rep_q, rep_d;
    logic                 prev_q, prev_d;
    logic [7:0]           shift_q, shift_d, hold_q, hold_d;
    logic [3:0]           nbits_q, nbits_d;
    logic                 valid_q, valid_d, sel_q, sel_d;
    logic                 raw, sampling, strobe, health_fail;
    logic                 bit_valid, bit_val, byte_full, byte_load, clr_data;

    assign sync1_d  = cell_data_i;
    assign sync2_d  = sync1_q;
    assign raw      = ^sync2_q;
    assign sampling = (state_q == StWarmup) || (state_q == StRun);
    assign strobe   = sampling && (div_q == DivW'(SAMPLE_DIV - 1));
    assign div_d    = (!sampling || strobe) ? '0 : div_q + 1'b1;

    // Repetition-count health test over every strobed sample in WARMUP and RUN.
    always_comb begin
        rep_d       = rep_q;
        prev_d      = prev_q;
        health_fail = 1'b0;
        if (!sampling) begin
            rep_d  = '0;
            prev_d = 1'b0;
        end else if (strobe) begin
            prev_d      = raw;
            rep_d       = (rep_q != '0 && raw == prev_q) ? rep_q + 1'b1 : RepW'(1);
            health_fail = (rep_d == RepW'(REP_LIMIT));
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        warm_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (en_i) state_d = StChain;
            end
            StChain: begin
                tmo_d = tmo_q + 1'b1;
                if (cell_chain_i) begin
                    state_d = StWarmup;
                end else if (tmo_d == TmoW'(CHAIN_TIMEOUT)) begin
                    state_d = StFault;
                end
            end
            StWarmup: begin
                warm_d = warm_q;
                if (health_fail) begin
                    state_d = StFault;
                end else if (strobe) begin
                    warm_d = warm_q + 1'b1;
                    if (warm_d == WarmW'(WARMUP_SAMPLES)) state_d = StRun;
                end
            end
            StRun: begin
                if (health_fail) state_d = StFault;
            end
            StFault: begin
                state_d = StFault;
            end
            default: state_d = StIdle;
        endcase
        if (!en_i) state_d = StIdle;
    end

    celltrng_sample_ctrl_vn_debias u_debias (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (state_q != StRun),
        .sample_i    (strobe && (state_q == StRun)),
        .data_i      (raw),
        .bit_valid_o (bit_valid),
        .bit_o       (bit_val)
    );

    // A completed byte parks in the shifter until the holding register can take it.
    assign byte_full = (nbits_q == 4'd8);
    assign byte_load = byte_full && (!valid_q || rnd_ready_i);
    assign clr_data  = (state_d != StRun);

    always_comb begin
        shift_d = shift_q;
        nbits_d = nbits_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        if (valid_q && rnd_ready_i) valid_d = 1'b0;
        if (byte_load) begin
            hold_d  = shift_q;
            valid_d = 1'b1;
            sel_d   = ~sel_q;
            nbits_d = '0;
        end
        if (bit_valid && (!byte_full || byte_load)) begin
            shift_d = {shift_q[6:0], bit_val};
            nbits_d = byte_load ? 4'd1 : nbits_q + 1'b1;
        end
        if (clr_data) begin
            shift_d = '0;
            nbits_d = '0;
            hold_d  = '0;
            valid_d = 1'b0;
        end
        if (state_d == StIdle) sel_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sync1_q <= '0;
            sync2_q <= '0;
            tmo_q   <= '0;
            div_q   <= '0;
            warm_q  <= '0;
            rep_q   <= '0;
            prev_q  <= 1'b0;
            shift_q <= '0;
            nbits_q <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            tmo_q   <= tmo_d;
            div_q   <= div_d;
            warm_q  <= warm_d;
            rep_q   <= rep_d;
            prev_q  <= prev_d;
            shift_q <= shift_d;
            nbits_q <= nbits_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign cell_enable_o = (state_q == StChain) || sampling;
    assign cell_select_o = {NUM_CELLS{sel_q}};
    assign rnd_data_o    = hold_q;
    assign rnd_valid_o   = valid_q;
    assign busy_o        = sampling;
    assign fault_o       = (state_q == StFault);

endmodule

// File: tb/tb_celltrng_sample_ctrl.sv
// Bench for celltrng_sample_ctrl: models the cells and checks against a sample-stream model.
module tb_celltrng_sample_ctrl;

    localparam int unsigned NCells = 3;
    localparam int unsigned Div    = 4;
    localparam int unsigned Warm   = 64;
    localparam int unsigned RepLim = 32;
    localparam int unsigned Tmo    = 1024;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              en_i = 1'b0;
    logic              cell_enable_o;
    logic              cell_chain_i = 1'b0;
    logic [NCells-1:0] cell_select_o;
    logic [NCells-1:0] cell_data_i = '0;
    logic [7:0]        rnd_data_o;
    logic              rnd_valid_o;
    logic              rnd_ready_i = 1'b0;
    logic              busy_o;
    logic              fault_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    celltrng_sample_ctrl #(
        .NUM_CELLS      (NCells),
        .SAMPLE_DIV     (Div),
        .WARMUP_SAMPLES (Warm),
        .REP_LIMIT      (RepLim),
        .CHAIN_TIMEOUT  (Tmo)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .cell_enable_o (cell_enable_o),
        .cell_chain_i  (cell_chain_i),
        .cell_select_o (cell_select_o),
        .cell_data_i   (cell_data_i),
        .rnd_data_o    (rnd_data_o),
        .rnd_valid_o   (rnd_valid_o),
        .rnd_ready_i   (rnd_ready_i),
        .busy_o        (busy_o),
        .fault_o       (fault_o)
    );

    // Reference model: operates on the stream of raw samples, one call per strobe.
    int         m_n, m_prev, m_rep, m_dropped;
    bit         m_phase, m_a, m_waiting, m_valid, m_sel, m_fault;
    bit         m_bits[$];
    logic [7:0] m_hold, m_wait_byte;

    function automatic void model_reset();
        m_n = 0; m_prev = -1; m_rep = 0; m_dropped = 0;
        m_phase = 0; m_a = 0; m_waiting = 0; m_valid = 0; m_sel = 0; m_fault = 0;
        m_bits.delete();
        m_hold = '0; m_wait_byte = '0;
    endfunction

    function automatic void model_emit(input bit b);
        logic [7:0] byte_v;
        if (m_waiting) begin
            m_dropped++;
            return;
        end
        m_bits.push_back(b);
        if (m_bits.size() == 8) begin
            byte_v = '0;
            for (int i = 0; i < 8; i++) byte_v = {byte_v[6:0], m_bits[i]};
            m_bits.delete();
            if (!m_valid) begin
                m_hold = byte_v; m_valid = 1; m_sel = ~m_sel;
            end else begin
                m_wait_byte = byte_v; m_waiting = 1;
            end
        end
    endfunction

    function automatic void model_sample(input bit r);
        if (m_fault) return;
        m_n++;
        m_rep = (m_prev == int'(r)) ? m_rep + 1 : 1;
        m_prev = int'(r);
        if (m_rep == int'(RepLim)) begin
            m_fault = 1; m_valid = 0; m_waiting = 0;
            m_bits.delete();
            return;
        end
        if (m_n <= int'(Warm)) return;
        if (!m_phase) begin
            m_a = r; m_phase = 1;
        end else begin
            m_phase = 0;
            if (m_a != r) model_emit(m_a);
        end
    endfunction

    function automatic void model_consume();
        if (!m_valid) return;
        if (m_waiting) begin
            m_hold = m_wait_byte; m_waiting = 0; m_sel = ~m_sel;
        end else begin
            m_valid = 0;
        end
    endfunction

    // One strobe period; entered and left on the negedge just after a strobe edge.
    task automatic sample_step(input bit r, input bit rdy);
        logic [NCells-1:0] d;
        d = NCells'($urandom);
        if ((^d) != r) d[0] = ~d[0];
        cell_data_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (rnd_valid_o !== m_valid) begin
            n_bad++;
            $display("FAIL step_valid: got %0b expected %0b (sample %0d)", rnd_valid_o, m_valid, m_n);
        end
        if (m_valid) begin
            n_total++;
            if (rnd_data_o !== m_hold) begin
                n_bad++;
                $display("FAIL step_data: got %02h expected %02h (sample %0d)", rnd_data_o, m_hold, m_n);
            end
        end
        n_total++;
        if (cell_select_o !== {NCells{m_sel}}) begin
            n_bad++;
            $display("FAIL step_select: got %0b expected %0b", cell_select_o, {NCells{m_sel}});
        end
        n_total++;
        if (fault_o !== m_fault) begin
            n_bad++;
            $display("FAIL step_fault: got %0b expected %0b (sample %0d)", fault_o, m_fault, m_n);
        end
        if (rdy) begin
            rnd_ready_i = 1'b1;
            model_consume();
        end
        @(posedge clk_i);
        #1 rnd_ready_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        model_sample(r);
    endtask

    task automatic do_warmup();
        model_reset();
        for (int i = 0; i < int'(Warm); i++) sample_step(i[0], 1'b0);
    endtask

    // From IDLE: enable, raise the chain 10 cycles later, then run through warmup.
    task automatic bring_up();
        @(negedge clk_i);
        cell_chain_i = 1'b0;
        en_i = 1'b1;
        @(posedge clk_i);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if ({cell_enable_o, busy_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL bringup_chain: got en/busy %0b expected 10", {cell_enable_o, busy_o});
        end
        cell_chain_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bringup_busy: got %0b expected 1", busy_o);
        end
        do_warmup();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        en_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if ({cell_enable_o, cell_select_o, rnd_data_o, rnd_valid_o, busy_o, fault_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {cell_enable_o, cell_select_o, rnd_data_o, rnd_valid_o, busy_o, fault_o});
        end
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (cell_enable_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_enable: got %0b expected 1", cell_enable_o);
        end
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        cell_chain_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL chain_busy: got %0b expected 1", busy_o);
        end
    endtask

    task automatic test_warmup();
        do_warmup();
        n_total++;
        if ({busy_o, rnd_valid_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL warmup_end: got busy/valid %0b expected 10", {busy_o, rnd_valid_o});
        end
    endtask

    task automatic test_debias();
        bit pairs [20] = '{1,0, 0,1, 1,1, 0,0, 1,0, 1,0, 0,1, 0,1, 1,0, 1,0};
        for (int i = 0; i < 20; i++) sample_step(pairs[i], 1'b0);
        sample_step(1'b0, 1'b0);
        n_total++;
        if (rnd_data_o !== 8'hB3 || rnd_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL debias_byte: got %02h/%0b expected b3/1", rnd_data_o, rnd_valid_o);
        end
        n_total++;
        if (cell_select_o !== 3'b111) begin
            n_bad++;
            $display("FAIL debias_select: got %0b expected 111", cell_select_o);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] second;
        for (int i = 0; i < 600 && !(m_waiting && m_dropped >= 8); i++) begin
            sample_step(1'($urandom), 1'b0);
        end
        n_total++;
        if (rnd_data_o !== 8'hB3) begin
            n_bad++;
            $display("FAIL bp_hold_first: got %02h expected b3", rnd_data_o);
        end
        second = m_wait_byte;
        sample_step(1'($urandom), 1'b1);
        n_total++;
        if (rnd_data_o !== second || rnd_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_second: got %02h/%0b expected %02h/1", rnd_data_o, rnd_valid_o, second);
        end
        sample_step(1'($urandom), 1'b1);
        n_total++;
        if (rnd_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got valid %0b expected 0", rnd_valid_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) sample_step(1'($urandom), ($urandom_range(0, 2) == 0));
    endtask

    task automatic test_en_drop();
        for (int i = 0; i < 300 && !(m_valid && m_bits.size() > 0); i++) begin
            sample_step(1'($urandom), 1'b0);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (rnd_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL endrop_pending: got valid %0b expected 1", rnd_valid_o);
        end
        en_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if ({cell_enable_o, cell_select_o, rnd_valid_o, busy_o, fault_o} !== '0) begin
            n_bad++;
            $display("FAIL endrop_idle: got %0b expected 0",
                     {cell_enable_o, cell_select_o, rnd_valid_o, busy_o, fault_o});
        end
    endtask

    task automatic test_health();
        bring_up();
        for (int i = 0; i < 20; i++) sample_step(1'($urandom), ($urandom_range(0, 1) == 0));
        for (int i = 0; i < 40 && !m_fault; i++) begin
            sample_step(1'b1, 1'b0);
            n_total++;
            if (fault_o !== m_fault) begin
                n_bad++;
                $display("FAIL health_edge: got %0b expected %0b (sample %0d)", fault_o, m_fault, m_n);
            end
        end
        n_total++;
        if ({fault_o, rnd_valid_o, cell_enable_o, busy_o} !== 4'b1000) begin
            n_bad++;
            $display("FAIL health_fault: got %0b expected 1000",
                     {fault_o, rnd_valid_o, cell_enable_o, busy_o});
        end
        en_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (fault_o !== 1'b0) begin
            n_bad++;
            $display("FAIL health_clear: got %0b expected 0", fault_o);
        end
    endtask

    task automatic test_chain_timeout();
        cell_chain_i = 1'b0;
        en_i = 1'b1;
        @(posedge clk_i);
        repeat (Tmo - 1) @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if ({fault_o, cell_enable_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL tmo_before: got fault/en %0b expected 01", {fault_o, cell_enable_o});
        end
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if ({fault_o, cell_enable_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL tmo_fault: got fault/en %0b expected 10", {fault_o, cell_enable_o});
        end
        en_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_total++;
        if (fault_o !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_clear: got %0b expected 0", fault_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_warmup();
        test_debias();
        test_backpressure();
        test_random();
        test_en_drop();
        test_health();
        test_chain_timeout();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
